// File: rtl/fpu_arith_pkg.sv
// Shared opcodes, dispatcher states, flag/condition-code bit positions and
// the FP80 indefinite constant used by the FPU arithmetic dispatcher.
package fpu_arith_pkg;

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_MUL    = 4'd2;
  localparam logic [3:0] OP_DIV    = 4'd3;
  localparam logic [3:0] OP_I16FP  = 4'd4;
  localparam logic [3:0] OP_I32FP  = 4'd5;
  localparam logic [3:0] OP_FPI16  = 4'd6;
  localparam logic [3:0] OP_FPI32  = 4'd7;
  localparam logic [3:0] OP_F32FP  = 4'd8;
  localparam logic [3:0] OP_F64FP  = 4'd9;
  localparam logic [3:0] OP_FPF32  = 4'd10;
  localparam logic [3:0] OP_FPF64  = 4'd11;
  localparam logic [3:0] OP_SQRT   = 4'd12;
  localparam logic [3:0] OP_SIN    = 4'd13;
  localparam logic [3:0] OP_COS    = 4'd14;
  localparam logic [3:0] OP_SINCOS = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_RESP_P = 3'd3,
    ST_RESP_S = 3'd4
  } disp_state_e;

  localparam int FLAG_INVALID     = 5;
  localparam int FLAG_DENORMAL    = 4;
  localparam int FLAG_ZERO_DIVIDE = 3;
  localparam int FLAG_OVERFLOW    = 2;
  localparam int FLAG_UNDERFLOW   = 1;
  localparam int FLAG_INEXACT     = 0;

  localparam int CC_LESS      = 3;
  localparam int CC_EQUAL     = 2;
  localparam int CC_GREATER   = 1;
  localparam int CC_UNORDERED = 0;

  localparam logic [79:0] FP80_INDEFINITE = 80'hFFFF_C000_0000_0000_0000;
  localparam logic [5:0]  FLAGS_TIMEOUT   = 6'(1) << FLAG_INVALID;
  localparam logic [3:0]  CC_TIMEOUT      = 4'(1) << CC_UNORDERED;

endpackage

// File: rtl/fpu_result_pack.sv
// Selects the 80-bit response word for an opcode; narrow conversion results
// are zero-extended, everything else passes the unit's full-width result.
module fpu_result_pack
  import fpu_arith_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [79:0] result,
  input  logic [15:0] int16_out,
  input  logic [31:0] int32_out,
  input  logic [31:0] fp32_out,
  input  logic [63:0] fp64_out,
  output logic [79:0] packed_data
);

  always_comb begin
    packed_data = result;
    unique case (op)
      OP_FPI16: packed_data = {64'b0, int16_out};
      OP_FPI32: packed_data = {48'b0, int32_out};
      OP_FPF32: packed_data = {48'b0, fp32_out};
      OP_FPF64: packed_data = {16'b0, fp64_out};
      default:  packed_data = result;
    endcase
  end

endmodule

// File: rtl/fpu_arith_dispatcher.sv
// Command-side initiator for the FPU arithmetic unit: latches one request,
// pulses the unit enable, waits for done (with timeout) and streams results.
module fpu_arith_dispatcher
  import fpu_arith_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TAG_W          = 3
)
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [1:0]       cmd_rmode,
  input  logic [79:0]      cmd_a,
  input  logic [79:0]      cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [3:0]       au_operation,
  output logic             au_enable,
  output logic [1:0]       au_rounding_mode,
  output logic [79:0]      au_operand_a,
  output logic [79:0]      au_operand_b,
  output logic [15:0]      au_int16_in,
  output logic [31:0]      au_int32_in,
  output logic [31:0]      au_fp32_in,
  output logic [63:0]      au_fp64_in,
  input  logic [79:0]      au_result,
  input  logic [79:0]      au_result_secondary,
  input  logic             au_has_secondary,
  input  logic [15:0]      au_int16_out,
  input  logic [31:0]      au_int32_out,
  input  logic [31:0]      au_fp32_out,
  input  logic [63:0]      au_fp64_out,
  input  logic             au_done,
  input  logic [5:0]       au_flags,
  input  logic [3:0]       au_cc,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [79:0]      rsp_data,
  output logic             rsp_last,
  output logic [5:0]       rsp_flags,
  output logic [3:0]       rsp_cc,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_timeout,
  output logic             busy
);

  localparam int              CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  disp_state_e      r_state;
  logic [3:0]       r_op;
  logic [1:0]       r_rmode;
  logic [79:0]      r_a;
  logic [79:0]      r_b;
  logic [TAG_W-1:0] r_tag;
  logic [CNT_W-1:0] r_cnt;
  logic [79:0]      r_data;
  logic [79:0]      r_sec;
  logic             r_has_sec;
  logic [5:0]       r_flags;
  logic [3:0]       r_cc;
  logic             r_timeout;
  logic [79:0]      w_packed;

  fpu_result_pack u_pack (
    .op          (r_op),
    .result      (au_result),
    .int16_out   (au_int16_out),
    .int32_out   (au_int32_out),
    .fp32_out    (au_fp32_out),
    .fp64_out    (au_fp64_out),
    .packed_data (w_packed)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_op      <= '0;
      r_rmode   <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_tag     <= '0;
      r_cnt     <= '0;
      r_data    <= '0;
      r_sec     <= '0;
      r_has_sec <= 1'b0;
      r_flags   <= '0;
      r_cc      <= '0;
      r_timeout <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_op    <= cmd_op;
            r_rmode <= cmd_rmode;
            r_a     <= cmd_a;
            r_b     <= cmd_b;
            r_tag   <= cmd_tag;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_cnt   <= '0;
          r_state <= ST_WAIT;
        end
        // done is level-held from the previous op until enable, so it is only trusted here
        ST_WAIT: begin
          if (au_done) begin
            r_data    <= w_packed;
            r_sec     <= au_result_secondary;
            r_has_sec <= au_has_secondary;
            r_flags   <= au_flags;
            r_cc      <= au_cc;
            r_timeout <= 1'b0;
            r_state   <= ST_RESP_P;
          end else if (r_cnt == CNT_LAST) begin
            r_data    <= FP80_INDEFINITE;
            r_sec     <= '0;
            r_has_sec <= 1'b0;
            r_flags   <= FLAGS_TIMEOUT;
            r_cc      <= CC_TIMEOUT;
            r_timeout <= 1'b1;
            r_state   <= ST_RESP_P;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_RESP_P: begin
          if (rsp_ready) r_state <= r_has_sec ? ST_RESP_S : ST_IDLE;
        end
        ST_RESP_S: begin
          if (rsp_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cmd_ready   = (r_state == ST_IDLE);
    busy        = (r_state != ST_IDLE);
    au_enable   = (r_state == ST_ISSUE);
    rsp_valid   = 1'b0;
    rsp_data    = '0;
    rsp_last    = 1'b0;
    rsp_flags   = '0;
    rsp_cc      = '0;
    rsp_tag     = '0;
    rsp_timeout = 1'b0;
    if (r_state == ST_RESP_P) begin
      rsp_valid   = 1'b1;
      rsp_data    = r_data;
      rsp_last    = ~r_has_sec;
      rsp_flags   = r_flags;
      rsp_cc      = r_cc;
      rsp_tag     = r_tag;
      rsp_timeout = r_timeout;
    end else if (r_state == ST_RESP_S) begin
      rsp_valid   = 1'b1;
      rsp_data    = r_sec;
      rsp_last    = 1'b1;
      rsp_tag     = r_tag;
      rsp_timeout = r_timeout;
    end
  end

  assign au_operation     = r_op;
  assign au_rounding_mode = r_rmode;
  assign au_operand_a     = r_a;
  assign au_operand_b     = r_b;
  assign au_int16_in      = r_a[15:0];
  assign au_int32_in      = r_a[31:0];
  assign au_fp32_in       = r_a[31:0];
  assign au_fp64_in       = r_a[63:0];

endmodule

// File: tb/tb_fpu_arith_dispatcher.sv
// Directed bench for fpu_arith_dispatcher with a small delayed-done unit model.
module tb_fpu_arith_dispatcher;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = '0;
  logic [1:0]  cmd_rmode = '0;
  logic [79:0] cmd_a = '0;
  logic [79:0] cmd_b = '0;
  logic [2:0]  cmd_tag = '0;
  logic [3:0]  au_operation;
  logic        au_enable;
  logic [1:0]  au_rounding_mode;
  logic [79:0] au_operand_a, au_operand_b;
  logic [15:0] au_int16_in;
  logic [31:0] au_int32_in, au_fp32_in;
  logic [63:0] au_fp64_in;
  logic [79:0] m_result = '0;
  logic [79:0] m_sec = '0;
  logic        m_has_sec = 1'b0;
  logic [15:0] m_int16 = '0;
  logic [31:0] m_int32 = '0;
  logic [31:0] m_fp32 = '0;
  logic [63:0] m_fp64 = '0;
  logic        m_done;
  logic [5:0]  m_flags = '0;
  logic [3:0]  m_cc = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [79:0] rsp_data;
  logic        rsp_last;
  logic [5:0]  rsp_flags;
  logic [3:0]  rsp_cc;
  logic [2:0]  rsp_tag;
  logic        rsp_timeout;
  logic        busy;

  int m_delay = 3;
  int m_cnt;
  int en_cnt = 0;
  int n_checks = 0;
  int n_errors = 0;

  fpu_arith_dispatcher #(.TIMEOUT_CYCLES(16), .TAG_W(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_rmode(cmd_rmode),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .au_operation(au_operation), .au_enable(au_enable), .au_rounding_mode(au_rounding_mode),
    .au_operand_a(au_operand_a), .au_operand_b(au_operand_b),
    .au_int16_in(au_int16_in), .au_int32_in(au_int32_in), .au_fp32_in(au_fp32_in),
    .au_fp64_in(au_fp64_in),
    .au_result(m_result), .au_result_secondary(m_sec), .au_has_secondary(m_has_sec),
    .au_int16_out(m_int16), .au_int32_out(m_int32), .au_fp32_out(m_fp32),
    .au_fp64_out(m_fp64), .au_done(m_done), .au_flags(m_flags), .au_cc(m_cc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .rsp_flags(rsp_flags), .rsp_cc(rsp_cc), .rsp_tag(rsp_tag), .rsp_timeout(rsp_timeout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Unit model: done rises m_delay cycles after the enable cycle; m_delay=0 never finishes.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_done <= 1'b0;
      m_cnt  <= 0;
    end else if (au_enable) begin
      m_done <= 1'b0;
      m_cnt  <= m_delay - 1;
    end else if (m_cnt == 1) begin
      m_done <= 1'b1;
      m_cnt  <= 0;
    end else if (m_cnt > 1) begin
      m_cnt <= m_cnt - 1;
    end
  end

  always @(posedge clk) if (au_enable) en_cnt <= en_cnt + 1;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [1:0] rm, input logic [79:0] a,
                       input logic [79:0] b, input logic [2:0] tag);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_rmode = rm;
    cmd_a     = a;
    cmd_b     = b;
    cmd_tag   = tag;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int cyc, output bit ready_seen);
    cyc = 0;
    ready_seen = 1'b0;
    while (!rsp_valid && cyc < 100) begin
      step();
      cyc++;
      if (cmd_ready) ready_seen = 1'b1;
    end
  endtask

  int  cyc;
  bit  rdy_seen;
  bit  stable;
  int  en0;

  initial begin
    // Reset state
    #12;
    chk("rst_cmd_ready", 80'(cmd_ready), 80'(1));
    chk("rst_rsp_valid", 80'(rsp_valid), 80'(0));
    chk("rst_busy", 80'(busy), 80'(0));
    chk("rst_au_enable", 80'(au_enable), 80'(0));
    chk("rst_rsp_data", rsp_data, 80'(0));
    reset_n = 1'b1;
    step();

    // 1: ADD 1.0 + 1.0 -> 2.0
    m_delay = 3; m_result = 80'h4000_8000_0000_0000_0000; m_flags = 6'b000001; m_cc = 4'b0010;
    en0 = en_cnt;
    issue(4'd0, 2'd2, 80'h3FFF_8000_0000_0000_0000, 80'h3FFF_8000_0000_0000_0000, 3'd5);
    chk("add_enable", 80'(au_enable), 80'(1));
    chk("add_busy_ready", 80'({busy, cmd_ready}), 80'(2'b10));
    chk("add_operand_a", au_operand_a, 80'h3FFF_8000_0000_0000_0000);
    chk("add_rmode", 80'(au_rounding_mode), 80'(2));
    wait_rsp(cyc, rdy_seen);
    chk("add_latency", 80'(cyc), 80'(4));
    chk("add_data", rsp_data, 80'h4000_8000_0000_0000_0000);
    chk("add_last_tag_to", 80'({rsp_last, rsp_tag, rsp_timeout}), 80'({1'b1, 3'd5, 1'b0}));
    chk("add_flags_cc", 80'({rsp_flags, rsp_cc}), 80'({6'b000001, 4'b0010}));
    step();
    chk("add_idle_after", 80'({cmd_ready, rsp_valid}), 80'(2'b10));
    chk("add_one_enable", 80'(en_cnt - en0), 80'(1));

    // 2: SINCOS with back-pressure
    m_result = 80'h3FFE_B504_F333_F9DE_6484; m_sec = 80'h3FFE_B504_F333_F9DE_6485;
    m_has_sec = 1'b1; m_flags = 6'b000001; m_cc = 4'b0000;
    rsp_ready = 1'b0;
    issue(4'd15, 2'd0, 80'h3FFE_C90F_DAA2_2168_C235, 80'h0, 3'd3);
    wait_rsp(cyc, rdy_seen);
    chk("sc_latency", 80'(cyc), 80'(4));
    chk("sc_p_data", rsp_data, 80'h3FFE_B504_F333_F9DE_6484);
    chk("sc_p_last", 80'(rsp_last), 80'(0));
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (!rsp_valid || rsp_data !== 80'h3FFE_B504_F333_F9DE_6484 || rsp_last !== 1'b0 ||
          rsp_tag !== 3'd3 || rsp_flags !== 6'b000001) stable = 1'b0;
    end
    chk("sc_p_stable", 80'(stable), 80'(1));
    rsp_ready = 1'b1;
    step();
    chk("sc_s_data", rsp_data, 80'h3FFE_B504_F333_F9DE_6485);
    chk("sc_s_last_tag", 80'({rsp_valid, rsp_last, rsp_tag}), 80'({1'b1, 1'b1, 3'd3}));
    chk("sc_s_flags_cc", 80'({rsp_flags, rsp_cc}), 80'(0));
    step();
    chk("sc_idle_after", 80'({cmd_ready, rsp_valid}), 80'(2'b10));
    m_has_sec = 1'b0;

    // 3: FP->I16 narrow result
    m_int16 = 16'hFFFE; m_result = 80'h1111_2222_3333_4444_5555; m_flags = 6'b0; m_cc = 4'b0;
    issue(4'd6, 2'd1, 80'hAAAA_BBBB_CCCC_DDDD_1234, 80'h0, 3'd6);
    chk("i16_in", 80'(au_int16_in), 80'(16'h1234));
    chk("i32_in", 80'(au_int32_in), 80'(32'hDDDD_1234));
    chk("f64_in", 80'(au_fp64_in), 80'(64'hBBBB_CCCC_DDDD_1234));
    wait_rsp(cyc, rdy_seen);
    chk("i16_data", rsp_data, 80'h0000_0000_0000_0000_FFFE);
    chk("i16_tag", 80'(rsp_tag), 80'(6));
    step();

    // 4: timeout with TIMEOUT_CYCLES=16
    m_delay = 0;
    issue(4'd3, 2'd0, 80'h3FFF_8000_0000_0000_0000, 80'h0, 3'd2);
    wait_rsp(cyc, rdy_seen);
    chk("to_latency", 80'(cyc), 80'(17));
    chk("to_data", rsp_data, 80'hFFFF_C000_0000_0000_0000);
    chk("to_flags", 80'(rsp_flags), 80'(6'b100000));
    chk("to_cc", 80'(rsp_cc), 80'(4'b0001));
    chk("to_timeout_last", 80'({rsp_timeout, rsp_last}), 80'(2'b11));
    step();

    // 5: async reset during WAIT, then a fresh ADD
    m_delay = 3; m_result = 80'h4000_C000_0000_0000_0000;
    issue(4'd2, 2'd3, 80'h4000_8000_0000_0000_0000, 80'h3FFF_C000_0000_0000_0000, 3'd7);
    step();
    #2 reset_n = 1'b0;
    #1;
    chk("ar_cmd_ready_busy", 80'({cmd_ready, busy}), 80'(2'b10));
    chk("ar_au_outputs", 80'({au_operation, au_rounding_mode, au_enable}), 80'(0));
    chk("ar_operand_a", au_operand_a, 80'(0));
    chk("ar_rsp", 80'({rsp_valid, rsp_tag, rsp_data}), 80'(0));
    #3 reset_n = 1'b1;
    step();
    m_result = 80'h4000_8000_0000_0000_0000;
    issue(4'd0, 2'd0, 80'h3FFF_8000_0000_0000_0000, 80'h3FFF_8000_0000_0000_0000, 3'd4);
    wait_rsp(cyc, rdy_seen);
    chk("ar_add_latency", 80'(cyc), 80'(4));
    chk("ar_add_data", rsp_data, 80'h4000_8000_0000_0000_0000);
    step();

    // 6: cmd_valid held high across a MUL
    m_result = 80'h4001_C000_0000_0000_0000;
    en0 = en_cnt;
    cmd_valid = 1'b1; cmd_op = 4'd2; cmd_rmode = 2'd0;
    cmd_a = 80'h4000_C000_0000_0000_0000; cmd_b = 80'h4000_8000_0000_0000_0000; cmd_tag = 3'd1;
    step();
    cmd_a = 80'h4001_A000_0000_0000_0000; cmd_tag = 3'd2;
    wait_rsp(cyc, rdy_seen);
    chk("mul_ready_low", 80'(rdy_seen), 80'(0));
    chk("mul_latency", 80'(cyc), 80'(4));
    chk("mul_tag1", 80'(rsp_tag), 80'(1));
    chk("mul_data", rsp_data, 80'h4001_C000_0000_0000_0000);
    step();
    chk("mul_ready_after", 80'({cmd_ready, busy}), 80'(2'b10));
    step();
    cmd_valid = 1'b0;
    chk("mul2_enable", 80'(au_enable), 80'(1));
    chk("mul2_operand_a", au_operand_a, 80'h4001_A000_0000_0000_0000);
    wait_rsp(cyc, rdy_seen);
    chk("mul2_tag", 80'(rsp_tag), 80'(2));
    step();
    chk("mul_enable_count", 80'(en_cnt - en0), 80'(2));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
